irrigacao_zonas_ctrl: RTL and testbench
=======================================

// Module: irrigacao_zonas_ctrl
// PURPOSE
//  Clocked, multi-zone successor of the combinational irrigation controller.
//  - Debounces the tank-level and climate sensors; latches a tank alarm; drives the fill valve with hysteresis.
//  - Runs one drip/sprinkler state machine per zone, with single-sprinkler arbitration.
//  - Scans a 2-digit 7-segment display (tank level, selected-zone mode) and drives the buzzer.
// PARAMETERS
//  N_ZONES     2    number of irrigation zones (1..8); ZW = (N_ZONES>1) ? $clog2(N_ZONES) : 1
//  DEB_CYCLES  4    cycles a synchronised input must be stable before it is accepted
//  DRIP_MAX    1000 max DRIP cycles with soil still dry before escalating to SPRAY
//  SPRAY_MAX   500  max SPRAY cycles before forced COOLDOWN
//  COOL_CYCLES 200  COOLDOWN length in cycles
//  SCAN_DIV    64   display digit-switch period in cycles
//  BUZZ_DIV    256  buzzer half-period in cycles (BUZZ_PULSE_EN only)
// PORTS
//  clk        in  1        system clock, rising edge
//  rst        in  1        synchronous reset, active-high
//  lvl_a      in  1        tank-high sensor, 1 = water present
//  lvl_m      in  1        tank-mid sensor
//  lvl_b      in  1        tank-low sensor
//  soil_dry   in  N_ZONES  per-zone soil-dry sensor, 1 = dry
//  air_dry    in  1        air-humidity-low sensor
//  temp_high  in  1        temperature-high sensor
//  alarm_ack  in  1        single-cycle alarm acknowledge
//  disp_zone  in  ZW       zone shown on digit 1; values >= N_ZONES show zone 0
//  alarm      out 1        latched tank alarm
//  valve      out 1        fill valve open
//  drip       out N_ZONES  per-zone drip output
//  spray      out N_ZONES  per-zone sprinkler output, one-hot or zero
//  seg        out 7        segments a..g = seg[6:0], active-high
//  dig_en     out 2        digit enables, one-hot, active-high
//  buzz       out 1        buzzer drive
// BEHAVIOUR
//  - Reset: every output, counter and FSM is 0/IDLE; debounced sensor values are 0; dig_en = 2'b01.
//  - Sensor input path: 2-flop synchroniser, then a debounce counter.
//    - A new value is accepted after DEB_CYCLES consecutive equal samples; any change restarts the count.
//    - All outputs are registered, so a sensor change reaches the outputs in 2+DEB_CYCLES+1 cycles.
//  - Level decode (debounced):
//    - FAULT: non-thermometer code (a&!m, m&!b, a&!b).
//    - EMPTY: !b.
//    - Otherwise LOW (b only), MID (b,m) or HIGH (a,m,b).
//  - Alarm:
//    - Sets on FAULT or EMPTY.
//    - Clears only on the cycle alarm_ack=1 while the condition is absent.
//    - An ack while the condition is still present is ignored.
//  - Valve: opens when !m; closes when a; holds otherwise; forced 0 while FAULT.
//  - Zone FSM, per zone: IDLE -> DRIP/SPRAY -> COOLDOWN -> IDLE.
//    - IDLE -> SPRAY if soil_dry & !alarm & air_dry & temp_high & sprinkler free.
//    - IDLE -> DRIP if soil_dry & !alarm, in every other case.
//    - DRIP -> COOLDOWN when soil wet.
//    - DRIP -> SPRAY when the DRIP count reaches DRIP_MAX and the sprinkler is free; otherwise stay in DRIP, count saturated.
//    - SPRAY -> COOLDOWN when soil wet or the SPRAY count reaches SPRAY_MAX.
//    - COOLDOWN -> IDLE after COOL_CYCLES; soil_dry is ignored during COOLDOWN.
//    - Alarm set: every zone goes to IDLE on the next cycle with counters cleared; no COOLDOWN.
//  - Sprinkler arbitration:
//    - "Free" means no zone is in SPRAY and no other zone is granted this cycle.
//    - Among simultaneous requests, the lowest index wins; losers enter or stay in DRIP.
//  - drip[i] = (state==DRIP); spray[i] = (state==SPRAY).
//  - Display:
//    - dig_en toggles every SCAN_DIV cycles.
//    - Digit 0 shows the level: H, M, L, E (empty), F (fault).
//    - Digit 1 shows the mode of zone disp_zone: 0, d, S, C.
//    - seg follows the digit selected in the same cycle.
//  - Counters saturate and never wrap. A reset mid-irrigation drops all outputs on the next edge.
// CONFIGURATION
//  - BUZZ_PULSE_EN defined: while alarm=1, buzz toggles every BUZZ_DIV cycles, starting at 1 on the cycle alarm sets; buzz=0 otherwise.
//  - BUZZ_PULSE_EN undefined: buzz = alarm, steady; no BUZZ_DIV counter is built.
// STRUCTURE
//  - Package irrigacao_pkg:
//    - zone_state_t enum {Z_IDLE, Z_DRIP, Z_SPRAY, Z_COOL};
//    - level_t enum {LV_EMPTY, LV_LOW, LV_MID, LV_HIGH, LV_FAULT};
//    - 7-bit segment constants SEG_H, SEG_M, SEG_L, SEG_E, SEG_F, SEG_0, SEG_D, SEG_S, SEG_C.
//  - Sub-module filtro_debounce (params DEB_CYCLES; ports clk, rst, din, dout):
//    - one instance per scalar sensor, one per soil_dry bit;
//    - it contains the synchroniser.
//  - Zone FSMs: generate loop; arbitration is combinational in the top level.
// TESTING (bench: N_ZONES=2, DEB_CYCLES=4, DRIP_MAX=20, SPRAY_MAX=10, COOL_CYCLES=5, SCAN_DIV=4, BUZZ_DIV=3)
//  - Level fill: a,m,b=0,0,1 -> valve=1 and digit0=L by cycle 7; then 0,1,1 -> valve stays 1; then 1,1,1 -> valve=0, digit0=H.
//  - Glitch: lvl_b low for 3 cycles only -> alarm stays 0; low for 4+ cycles -> alarm=1, and buzz pulses 1,1,1,0,0,0 (pulse mode).
//  - Fault: a=1, m=0, b=1 -> alarm=1, valve=0, digit0=F, zones IDLE; ack while fault -> alarm stays 1; ack after 1,1,1 -> alarm=0.
//  - Escalation: soil_dry=2'b01 held -> drip=01 after debounce; 20 cycles later spray=01, drip=00; 10 cycles later both 0 (COOLDOWN) for 5 cycles, then re-entry.
//  - Arbitration: soil_dry=11, air_dry=1, temp_high=1 together -> spray=01, drip=10; zone 0 leaves SPRAY -> zone 1 takes SPRAY only after its DRIP_MAX.
//  - Reset mid-SPRAY: rst=1 for 1 cycle -> next edge: all outputs 0, dig_en=01, states IDLE.

Source files
------------

// File: rtl/irrigacao_pkg.sv
// Shared types, 7-segment glyphs and decode helpers for the multi-zone irrigation controller.
package irrigacao_pkg;

    typedef enum logic [1:0] {Z_IDLE, Z_DRIP, Z_SPRAY, Z_COOL} zone_state_t;
    typedef enum logic [2:0] {LV_EMPTY, LV_LOW, LV_MID, LV_HIGH, LV_FAULT} level_t;

    // Segment order is a..g on bits 6..0, active-high.
    localparam logic [6:0] SEG_H = 7'b0110111;
    localparam logic [6:0] SEG_M = 7'b1110110;
    localparam logic [6:0] SEG_L = 7'b0001110;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_S = 7'b1011011;
    localparam logic [6:0] SEG_C = 7'b1001110;

    function automatic level_t decode_level(input logic a, input logic m, input logic b);
        if ((a && !m) || (m && !b) || (a && !b)) return LV_FAULT;
        else if (!b)                             return LV_EMPTY;
        else if (a)                              return LV_HIGH;
        else if (m)                              return LV_MID;
        else                                     return LV_LOW;
    endfunction

    function automatic logic [6:0] level_seg(input level_t lv);
        case (lv)
            LV_HIGH:  return SEG_H;
            LV_MID:   return SEG_M;
            LV_LOW:   return SEG_L;
            LV_EMPTY: return SEG_E;
            default:  return SEG_F;
        endcase
    endfunction

    function automatic logic [6:0] mode_seg(input zone_state_t st);
        case (st)
            Z_DRIP:  return SEG_D;
            Z_SPRAY: return SEG_S;
            Z_COOL:  return SEG_C;
            default: return SEG_0;
        endcase
    endfunction

endpackage

// File: rtl/filtro_debounce.sv
// Two-flop synchroniser followed by a stability counter; dout follows din only after
// DEB_CYCLES consecutive equal synchronised samples.
module filtro_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_reg, sync2_reg, dout_reg;
    logic [DW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            dout_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            // A binary input differing from dout on consecutive samples means a stable new value.
            if (sync2_reg != dout_reg) begin
                if (cnt_reg == DW'(DEB_CYCLES - 1)) begin
                    dout_reg <= sync2_reg;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign dout = dout_reg;
endmodule

// File: rtl/irrigacao_zonas_ctrl.sv
// Multi-zone irrigation controller: debounced tank/climate sensors, alarm latch, fill valve,
// per-zone drip/spray FSMs with single-sprinkler arbitration, 2-digit display. Option: BUZZ_PULSE_EN.
module irrigacao_zonas_ctrl
    import irrigacao_pkg::*;
#(
    parameter int N_ZONES     = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int DRIP_MAX    = 1000,
    parameter int SPRAY_MAX   = 500,
    parameter int COOL_CYCLES = 200,
    parameter int SCAN_DIV    = 64,
    parameter int BUZZ_DIV    = 256,
    localparam int ZW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lvl_a,
    input  logic               lvl_m,
    input  logic               lvl_b,
    input  logic [N_ZONES-1:0] soil_dry,
    input  logic               air_dry,
    input  logic               temp_high,
    input  logic               alarm_ack,
    input  logic [ZW-1:0]      disp_zone,
    output logic               alarm,
    output logic               valve,
    output logic [N_ZONES-1:0] drip,
    output logic [N_ZONES-1:0] spray,
    output logic [6:0]         seg,
    output logic [1:0]         dig_en,
    output logic               buzz
);
    localparam int CNT_TOP = (DRIP_MAX > SPRAY_MAX)
                           ? ((DRIP_MAX > COOL_CYCLES) ? DRIP_MAX : COOL_CYCLES)
                           : ((SPRAY_MAX > COOL_CYCLES) ? SPRAY_MAX : COOL_CYCLES);
    localparam int CW = $clog2(CNT_TOP + 1);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic               a_dbn, m_dbn, b_dbn, air_dbn, temp_dbn;
    logic [N_ZONES-1:0] soil_dbn;

    filtro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a    (.clk(clk), .rst(rst), .din(lvl_a),     .dout(a_dbn));
    filtro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_m    (.clk(clk), .rst(rst), .din(lvl_m),     .dout(m_dbn));
    filtro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b    (.clk(clk), .rst(rst), .din(lvl_b),     .dout(b_dbn));
    filtro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_air  (.clk(clk), .rst(rst), .din(air_dry),   .dout(air_dbn));
    filtro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_temp (.clk(clk), .rst(rst), .din(temp_high), .dout(temp_dbn));

    level_t level;
    logic   fault, alarm_cond, alarm_next, alarm_block;
    logic   alarm_reg, valve_reg;

    assign level       = decode_level(a_dbn, m_dbn, b_dbn);
    assign fault       = (level == LV_FAULT);
    assign alarm_cond  = fault || (level == LV_EMPTY);
    assign alarm_next  = alarm_cond || (alarm_reg && !alarm_ack);
    // Zones see the condition itself too, so none can start on the edge the alarm sets.
    assign alarm_block = alarm_reg || alarm_cond;

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_reg <= 1'b0;
            valve_reg <= 1'b0;
        end else begin
            alarm_reg <= alarm_next;
            if (fault || a_dbn) valve_reg <= 1'b0;
            else if (!m_dbn)    valve_reg <= 1'b1;
        end
    end

    zone_state_t        state_reg [N_ZONES];
    logic [CW-1:0]      cnt_reg   [N_ZONES];
    logic [N_ZONES-1:0] req, grant;

    // Lowest-index requester wins, and only while no zone is already spraying.
    always_comb begin
        logic taken;
        taken = 1'b0;
        grant = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            if (state_reg[i] == Z_SPRAY) taken = 1'b1;
        end
        for (int i = 0; i < N_ZONES; i++) begin
            if (req[i] && !taken) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_ZONES; gi++) begin : g_zone
            filtro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_soil (
                .clk(clk), .rst(rst), .din(soil_dry[gi]), .dout(soil_dbn[gi]));

            assign req[gi] = soil_dbn[gi] &&
                             (((state_reg[gi] == Z_IDLE) && air_dbn && temp_dbn) ||
                              ((state_reg[gi] == Z_DRIP) && (cnt_reg[gi] == CW'(DRIP_MAX))));

            // cnt_reg counts cycles spent in the current state, starting at 1 on entry.
            always_ff @(posedge clk) begin
                if (rst || alarm_block) begin
                    state_reg[gi] <= Z_IDLE;
                    cnt_reg[gi]   <= '0;
                end else begin
                    case (state_reg[gi])
                        Z_IDLE: if (soil_dbn[gi]) begin
                            state_reg[gi] <= grant[gi] ? Z_SPRAY : Z_DRIP;
                            cnt_reg[gi]   <= CW'(1);
                        end
                        Z_DRIP: if (!soil_dbn[gi]) begin
                            state_reg[gi] <= Z_COOL;
                            cnt_reg[gi]   <= CW'(1);
                        end else if (grant[gi]) begin
                            state_reg[gi] <= Z_SPRAY;
                            cnt_reg[gi]   <= CW'(1);
                        end else if (cnt_reg[gi] != CW'(DRIP_MAX)) begin
                            cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                        end
                        Z_SPRAY: if (!soil_dbn[gi] || cnt_reg[gi] == CW'(SPRAY_MAX)) begin
                            state_reg[gi] <= Z_COOL;
                            cnt_reg[gi]   <= CW'(1);
                        end else begin
                            cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                        end
                        default: if (cnt_reg[gi] == CW'(COOL_CYCLES)) begin
                            state_reg[gi] <= Z_IDLE;
                            cnt_reg[gi]   <= '0;
                        end else begin
                            cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                        end
                    endcase
                end
            end

            assign drip[gi]  = (state_reg[gi] == Z_DRIP);
            assign spray[gi] = (state_reg[gi] == Z_SPRAY);
        end
    endgenerate

    logic [SW-1:0] scan_cnt_reg;
    logic [1:0]    dig_en_reg, dig_en_next;
    logic [6:0]    seg_reg, seg_next;
    logic [ZW-1:0] disp_sel;

    assign disp_sel = (int'(disp_zone) >= N_ZONES) ? '0 : disp_zone;

    always_comb begin
        dig_en_next = dig_en_reg;
        if (scan_cnt_reg == SW'(SCAN_DIV - 1)) dig_en_next = {dig_en_reg[0], dig_en_reg[1]};
        seg_next = dig_en_next[0] ? level_seg(level) : mode_seg(state_reg[disp_sel]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_reg <= '0;
            dig_en_reg   <= 2'b01;
            seg_reg      <= '0;
        end else begin
            scan_cnt_reg <= (scan_cnt_reg == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt_reg + 1'b1;
            dig_en_reg   <= dig_en_next;
            seg_reg      <= seg_next;
        end
    end

`ifdef BUZZ_PULSE_EN
    localparam int BW = $clog2(BUZZ_DIV + 1);
    logic [BW-1:0] buzz_cnt_reg;
    logic          buzz_reg;

    always_ff @(posedge clk) begin
        if (rst || !alarm_next) begin
            buzz_reg     <= 1'b0;
            buzz_cnt_reg <= '0;
        end else if (!alarm_reg) begin
            buzz_reg     <= 1'b1;
            buzz_cnt_reg <= BW'(1);
        end else if (buzz_cnt_reg == BW'(BUZZ_DIV)) begin
            buzz_reg     <= !buzz_reg;
            buzz_cnt_reg <= BW'(1);
        end else begin
            buzz_cnt_reg <= buzz_cnt_reg + 1'b1;
        end
    end
    assign buzz = buzz_reg;
`else
    assign buzz = alarm_reg;
`endif

    assign alarm  = alarm_reg;
    assign valve  = valve_reg;
    assign seg    = seg_reg;
    assign dig_en = dig_en_reg;
endmodule

// File: tb/tb_irrigacao_zonas_ctrl.sv
// Scoreboard bench for irrigacao_zonas_ctrl: expectations are queued with their due cycle
// when stimulus is applied and compared on the falling edge of that cycle.
module tb_irrigacao_zonas_ctrl;
    localparam int SCAN = 4;

    localparam logic [6:0] G_H = 7'b0110111;
    localparam logic [6:0] G_M = 7'b1110110;
    localparam logic [6:0] G_L = 7'b0001110;
    localparam logic [6:0] G_F = 7'b1000111;
    localparam logic [6:0] G_S = 7'b1011011;
    localparam logic [6:0] G_C = 7'b1001110;

    localparam int S_ALARM = 0, S_VALVE = 1, S_DRIP = 2, S_SPRAY = 3,
                   S_DIG = 4, S_BUZZ = 5, S_SEG = 6, S_DIG0 = 7, S_DIG1 = 8;

    logic       clk = 1'b0, rst = 1'b1;
    logic       lvl_a = 0, lvl_m = 0, lvl_b = 0, air_dry = 0, temp_high = 0, alarm_ack = 0;
    logic [1:0] soil_dry = '0;
    logic [0:0] disp_zone = '0;
    logic       alarm, valve, buzz;
    logic [1:0] drip, spray, dig_en;
    logic [6:0] seg;

    irrigacao_zonas_ctrl #(
        .N_ZONES(2), .DEB_CYCLES(4), .DRIP_MAX(20), .SPRAY_MAX(10),
        .COOL_CYCLES(5), .SCAN_DIV(SCAN), .BUZZ_DIV(3)
    ) dut (
        .clk(clk), .rst(rst), .lvl_a(lvl_a), .lvl_m(lvl_m), .lvl_b(lvl_b),
        .soil_dry(soil_dry), .air_dry(air_dry), .temp_high(temp_high),
        .alarm_ack(alarm_ack), .disp_zone(disp_zone),
        .alarm(alarm), .valve(valve), .drip(drip), .spray(spray),
        .seg(seg), .dig_en(dig_en), .buzz(buzz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] want;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0d: got %0h, want %0h", tag, cyc, got, want);
        end else begin
            $display("ok   %s @%0d: %0h", tag, cyc, got);
        end
    endtask

    task automatic expect_at(input int dly, input int sel, input logic [31:0] want, input string tag);
        sb_q.push_back('{cyc + dly, sel, want, tag});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        alarm_ack = 1'b1;
        tick(1);
        alarm_ack = 1'b0;
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_ALARM: return 32'(alarm);
            S_VALVE: return 32'(valve);
            S_DRIP:  return 32'(drip);
            S_SPRAY: return 32'(spray);
            S_DIG:   return 32'(dig_en);
            S_BUZZ:  return 32'(buzz);
            default: return 32'(seg);
        endcase
    endfunction

    // Digit entries wait for their digit to be scanned; others are compared on the due cycle.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= cyc) begin
                if (sb_q[i].sel == S_DIG0 || sb_q[i].sel == S_DIG1) begin
                    logic [1:0] want_dig;
                    want_dig = (sb_q[i].sel == S_DIG0) ? 2'b01 : 2'b10;
                    if (dig_en == want_dig) begin
                        check(sb_q[i].tag, 32'(seg), sb_q[i].want);
                        sb_q.delete(i);
                    end else if (cyc > sb_q[i].due + 3 * SCAN) begin
                        check({sb_q[i].tag, "_scan_timeout"}, 32'(dig_en), 32'(want_dig));
                        sb_q.delete(i);
                    end
                end else begin
                    check(sb_q[i].tag, observe(sb_q[i].sel), sb_q[i].want);
                    sb_q.delete(i);
                end
            end
        end
    end

    task automatic expect_buzz_burst(input int start);
`ifdef BUZZ_PULSE_EN
        for (int i = 0; i < 6; i++) expect_at(start + i, S_BUZZ, (i < 3) ? 1 : 0, "buzz_pulse");
`else
        for (int i = 0; i < 6; i++) expect_at(start + i, S_BUZZ, 1, "buzz_steady");
`endif
    endtask

    initial begin
        // Reset state, then release with every sensor low (tank reads EMPTY).
        tick(3);
        expect_at(0, S_ALARM, 0, "rst_alarm");
        expect_at(0, S_VALVE, 0, "rst_valve");
        expect_at(0, S_DRIP,  0, "rst_drip");
        expect_at(0, S_SPRAY, 0, "rst_spray");
        expect_at(0, S_DIG,   1, "rst_dig_en");
        expect_at(0, S_SEG,   0, "rst_seg");
        expect_at(0, S_BUZZ,  0, "rst_buzz");
        rst = 1'b0;
        expect_at(1, S_ALARM, 1, "empty_alarm");
        expect_at(1, S_BUZZ,  1, "empty_buzz");
        expect_at(1, S_VALVE, 1, "empty_valve_open");
        expect_at(3, S_DIG,   1, "scan_hold");
        expect_at(4, S_DIG,   2, "scan_toggle");

        // Level fill: LOW -> MID -> HIGH.
        tick(2);
        lvl_b = 1'b1;
        expect_at(7, S_VALVE, 1,   "low_valve");
        expect_at(7, S_DIG0,  G_L, "low_digit0");
        expect_at(7, S_ALARM, 1,   "low_alarm_held");
        tick(8);
        ack_pulse();
        expect_at(0, S_ALARM, 0, "ack_clears");
        expect_at(0, S_BUZZ,  0, "ack_buzz_off");
        lvl_m = 1'b1;
        expect_at(7, S_VALVE, 1,   "mid_valve");
        expect_at(7, S_DIG0,  G_M, "mid_digit0");
        tick(8);
        lvl_a = 1'b1;
        expect_at(6, S_VALVE, 1,   "high_valve_pre");
        expect_at(7, S_VALVE, 0,   "high_valve_closed");
        expect_at(7, S_DIG0,  G_H, "high_digit0");
        tick(10);

        // Glitch on lvl_b shorter than the debounce window, then a real drop.
        lvl_b = 1'b0;
        tick(3);
        lvl_b = 1'b1;
        expect_at(9, S_ALARM, 0, "glitch_ignored");
        tick(12);
        lvl_b = 1'b0;
        expect_at(6, S_ALARM, 0, "drop_latency");
        expect_at(7, S_ALARM, 1, "drop_alarm");
        expect_buzz_burst(7);
        tick(14);
        lvl_b = 1'b1;
        tick(8);
        ack_pulse();
        expect_at(0, S_ALARM, 0, "drop_ack");
        tick(4);

        // Fault (a=1, m=0, b=1) with a dry zone: zones must stay idle, ack ignored.
        lvl_m    = 1'b0;
        soil_dry = 2'b01;
        expect_at(7,  S_ALARM, 1,   "fault_alarm");
        expect_at(7,  S_VALVE, 0,   "fault_valve");
        expect_at(7,  S_DIG0,  G_F, "fault_digit0");
        expect_at(7,  S_DRIP,  0,   "fault_drip_idle_a");
        expect_at(12, S_DRIP,  0,   "fault_drip_idle_b");
        tick(9);
        soil_dry = 2'b00;
        ack_pulse();
        expect_at(0, S_ALARM, 1, "fault_ack_ignored");
        expect_at(1, S_ALARM, 1, "fault_ack_ignored2");
        tick(3);
        lvl_m = 1'b1;
        tick(8);
        ack_pulse();
        expect_at(0, S_ALARM, 0, "fault_cleared");
        tick(10);

        // Escalation of zone 0: DRIP 20 cycles, SPRAY 10, COOLDOWN 5, IDLE, DRIP again.
        soil_dry = 2'b01;
        expect_at(6,  S_DRIP,  0,   "esc_drip_pre");
        expect_at(7,  S_DRIP,  1,   "esc_drip");
        expect_at(26, S_DRIP,  1,   "esc_drip_last");
        expect_at(26, S_SPRAY, 0,   "esc_spray_pre");
        expect_at(27, S_SPRAY, 1,   "esc_spray");
        expect_at(27, S_DRIP,  0,   "esc_drip_off");
        expect_at(30, S_DIG1,  G_S, "esc_digit1_s");
        expect_at(36, S_SPRAY, 1,   "esc_spray_last");
        expect_at(37, S_SPRAY, 0,   "esc_cool_spray");
        expect_at(37, S_DRIP,  0,   "esc_cool_drip");
        expect_at(38, S_DIG1,  G_C, "esc_digit1_c");
        expect_at(42, S_DRIP,  0,   "esc_idle");
        expect_at(43, S_DRIP,  1,   "esc_reentry");
        tick(44);
        soil_dry = 2'b00;
        tick(16);

        // Arbitration: both zones request the sprinkler together.
        soil_dry  = 2'b11;
        air_dry   = 1'b1;
        temp_high = 1'b1;
        expect_at(7, S_SPRAY, 1, "arb_spray");
        expect_at(7, S_DRIP,  2, "arb_drip");
        tick(8);
        soil_dry = 2'b10;
        expect_at(6,  S_SPRAY, 1, "arb_z0_spray_hold");
        expect_at(7,  S_SPRAY, 0, "arb_z0_left");
        expect_at(7,  S_DRIP,  2, "arb_z1_drip");
        expect_at(18, S_SPRAY, 0, "arb_z1_wait");
        expect_at(18, S_DRIP,  2, "arb_z1_drip_max");
        expect_at(19, S_SPRAY, 2, "arb_z1_spray");
        expect_at(19, S_DRIP,  0, "arb_z1_drip_off");
        tick(22);

        // Reset for one cycle in the middle of zone 1's SPRAY.
        rst = 1'b1;
        expect_at(1, S_SPRAY, 0, "mid_rst_spray");
        expect_at(1, S_DRIP,  0, "mid_rst_drip");
        expect_at(1, S_ALARM, 0, "mid_rst_alarm");
        expect_at(1, S_VALVE, 0, "mid_rst_valve");
        expect_at(1, S_DIG,   1, "mid_rst_dig_en");
        expect_at(1, S_SEG,   0, "mid_rst_seg");
        expect_at(1, S_BUZZ,  0, "mid_rst_buzz");
        expect_at(2, S_ALARM, 1, "post_rst_alarm");
        expect_at(2, S_SPRAY, 0, "post_rst_spray");
        tick(1);
        rst = 1'b0;
        tick(5);

        for (int w = 0; w < 100 && sb_q.size() > 0; w++) tick(1);
        if (sb_q.size() > 0) check("scoreboard_drain", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
